// File: rtl/ll_fifo_drain_arbiter_if.sv
// ---------------------------------------------------------------------------
// ll_fifo_drain_arbiter_if
// Bundles the signals between the drain arbiter, the shared linked-list FIFO
// and the downstream consumer.
//   fifo_empty   per-queue empty flags from the shared FIFO
//   fifo_data    head word of the queue addressed by fifo_pop_sel
//   qmask        per-queue drain enable (1 = eligible)
//   fifo_pop     pop strobe to the shared FIFO
//   fifo_pop_sel queue being popped
//   out_valid    output buffer non-empty
//   out_ready    consumer accepts the head entry
//   out_data     head entry data
//   out_qid      queue id of the head entry
// Modport slave is the arbiter's view; master is the surrounding logic.
// ---------------------------------------------------------------------------
interface ll_fifo_drain_arbiter_if #(
   parameter int WIDTH     = 8,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
);
   logic [NUM_FIFOS-1:0] fifo_empty;
   logic [WIDTH-1:0]     fifo_data;
   logic [NUM_FIFOS-1:0] qmask;
   logic                 fifo_pop;
   logic [SEL_WIDTH-1:0] fifo_pop_sel;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [SEL_WIDTH-1:0] out_qid;

   modport slave (
      input  fifo_empty, fifo_data, qmask, out_ready,
      output fifo_pop, fifo_pop_sel, out_valid, out_data, out_qid
   );

   modport master (
      output fifo_empty, fifo_data, qmask, out_ready,
      input  fifo_pop, fifo_pop_sel, out_valid, out_data, out_qid
   );
endinterface

// File: rtl/ll_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// ll_fifo_drain_arbiter
// Drain stage for the shared linked-list FIFO. Picks a non-empty, enabled
// queue by round-robin, pops it, and captures {queue id, word} into a
// 2-entry output buffer that feeds the consumer over valid/ready. The pop
// decision uses only the registered buffer count, so consumer backpressure
// has no combinational path back to the shared FIFO.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  asynchronous, active-high reset
//   bus  ll_fifo_drain_arbiter_if.slave (FIFO side + consumer side)
// ---------------------------------------------------------------------------
module ll_fifo_drain_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
   input  logic                   clk,
   input  logic                   rst,
   ll_fifo_drain_arbiter_if.slave bus
);

   localparam logic [SEL_WIDTH-1:0] LAST_Q = SEL_WIDTH'(NUM_FIFOS - 1);

   logic [NUM_FIFOS-1:0] elig;
   logic [SEL_WIDTH-1:0] rr_ptr;
   logic [SEL_WIDTH-1:0] grant;
   logic [SEL_WIDTH-1:0] idx;
   logic                 found;
   logic [1:0]           count;
   logic                 pop;
   logic                 deq;
   logic [WIDTH-1:0]     head_data;
   logic [SEL_WIDTH-1:0] head_qid;
   logic [WIDTH-1:0]     tail_data;
   logic [SEL_WIDTH-1:0] tail_qid;

   assign elig = ~bus.fifo_empty & bus.qmask;

   // Round-robin search starting at rr_ptr; wrap is explicit so that
   // non-power-of-two queue counts never index past the last queue.
   always_comb begin
      grant = rr_ptr;
      found = 1'b0;
      idx   = rr_ptr;
      for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
         if (!found && elig[idx]) begin
            grant = idx;
            found = 1'b1;
         end
         idx = (idx == LAST_Q) ? '0 : idx + 1'b1;
      end
   end

   assign pop = ~rst & (count < 2'd2) & (|elig);
   assign deq = (count != 2'd0) & bus.out_ready;

   assign bus.fifo_pop     = pop;
   assign bus.fifo_pop_sel = pop ? grant : rr_ptr;
   assign bus.out_valid    = (count != 2'd0);
   assign bus.out_data     = head_data;
   assign bus.out_qid      = head_qid;

   // Head is always the oldest entry. A new word lands in the head when the
   // buffer is (or is about to become) empty, otherwise behind it in tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         rr_ptr    <= '0;
         head_data <= '0;
         head_qid  <= '0;
         tail_data <= '0;
         tail_qid  <= '0;
      end else begin
         count <= count + {1'b0, pop} - {1'b0, deq};
         if (pop) begin
            rr_ptr <= (grant == LAST_Q) ? '0 : grant + 1'b1;
         end
         if (pop && ((count == 2'd0) || ((count == 2'd1) && deq))) begin
            head_data <= bus.fifo_data;
            head_qid  <= grant;
         end else if (deq && (count == 2'd2)) begin
            head_data <= tail_data;
            head_qid  <= tail_qid;
         end
         if (pop && (count == 2'd1) && !deq) begin
            tail_data <= bus.fifo_data;
            tail_qid  <= grant;
         end
      end
   end

endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ll_fifo_drain_arbiter
// Table of per-cycle {inputs, expected pop/sel/valid} records applied in a
// loop; every expected capture is queued when its pop is expected and
// compared against the buffer head while out_valid is expected. Hand-written
// sequences cover the asynchronous mid-operation reset.
// ---------------------------------------------------------------------------
module tb_ll_fifo_drain_arbiter;

   typedef struct {
      logic [1:0] empty;
      logic [1:0] qmask;
      logic       ready;
      logic       exp_pop;
      logic       exp_sel;
      logic       exp_valid;
   } vec_t;

   typedef struct packed {
      logic       qid;
      logic [7:0] data;
   } sb_t;

   logic clk;
   logic rst;
   logic [7:0] word_base;
   int errors;
   int checks;
   int row;
   sb_t sb[$];
   vec_t vecs[22];

   ll_fifo_drain_arbiter_if #(.WIDTH(8), .NUM_FIFOS(2)) bus ();

   ll_fifo_drain_arbiter #(.WIDTH(8), .NUM_FIFOS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // First-word fall-through model of the shared FIFO head.
   assign bus.fifo_data = word_base + 8'(bus.fifo_pop_sel);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [1:0] e, input logic [1:0] m, input logic r,
                               input logic p, input logic s, input logic v);
      vec_t t;
      t.empty = e; t.qmask = m; t.ready = r;
      t.exp_pop = p; t.exp_sel = s; t.exp_valid = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge; checks before the next posedge.
   task automatic run_row(input vec_t v);
      sb_t e;
      bus.fifo_empty = v.empty;
      bus.qmask      = v.qmask;
      bus.out_ready  = v.ready;
      word_base      = 8'hA0 + 8'(row * 4);
      #1;
      chk($sformatf("row%0d pop", row), 32'(bus.fifo_pop), 32'(v.exp_pop));
      chk($sformatf("row%0d pop_sel", row), 32'(bus.fifo_pop_sel), 32'(v.exp_sel));
      chk($sformatf("row%0d out_valid", row), 32'(bus.out_valid), 32'(v.exp_valid));
      if (v.exp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL row%0d scoreboard: got empty queue expected an entry", row);
         end else begin
            e = sb[0];
            chk($sformatf("row%0d out_data", row), 32'(bus.out_data), 32'(e.data));
            chk($sformatf("row%0d out_qid", row), 32'(bus.out_qid), 32'(e.qid));
            if (v.ready) void'(sb.pop_front());
         end
      end
      if (v.exp_pop) begin
         e.qid  = v.exp_sel;
         e.data = word_base + 8'(v.exp_sel);
         sb.push_back(e);
      end
      row++;
      @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      row    = 0;
      word_base = 8'h00;

      //                empty  qmask  rdy   pop   sel   valid
      vecs[0]  = mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
      vecs[2]  = mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
      vecs[3]  = mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
      vecs[4]  = mk(2'b01, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
      vecs[5]  = mk(2'b01, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
      vecs[6]  = mk(2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
      vecs[7]  = mk(2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
      vecs[8]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      vecs[9]  = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
      vecs[10] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[11] = mk(2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
      vecs[13] = mk(2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs[14] = mk(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
      vecs[15] = mk(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
      vecs[16] = mk(2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
      vecs[17] = mk(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
      vecs[18] = mk(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[19] = mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
      vecs[20] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
      vecs[21] = mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);

      // Reset state, with both queues non-empty so pop must be held off.
      rst = 1'b1;
      bus.fifo_empty = 2'b00;
      bus.qmask      = 2'b11;
      bus.out_ready  = 1'b0;
      @(negedge clk);
      #1;
      chk("reset pop", 32'(bus.fifo_pop), 32'd0);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset out_data", 32'(bus.out_data), 32'd0);
      chk("reset out_qid", 32'(bus.out_qid), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) run_row(vecs[i]);

      // Fill the buffer to two entries, then reset asynchronously mid-cycle.
      run_row(mk(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0));
      run_row(mk(2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1));
      run_row(mk(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1));
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("async rst pop", 32'(bus.fifo_pop), 32'd0);
      chk("async rst out_data", 32'(bus.out_data), 32'd0);
      chk("async rst out_qid", 32'(bus.out_qid), 32'd0);
      @(negedge clk);
      #1;
      chk("rst held pop", 32'(bus.fifo_pop), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.fifo_empty = 2'b11;
      #1;
      chk("post rst empty pop", 32'(bus.fifo_pop), 32'd0);
      chk("post rst out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("post rst empty pop 2", 32'(bus.fifo_pop), 32'd0);
      @(negedge clk);
      sb.delete();

      // Pointer restarts at queue 0 after reset.
      run_row(mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0));
      run_row(mk(2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1));
      run_row(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
      run_row(mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
